// File: rtl/regbank_pkg.sv
// regbank_pkg
//   Shared constants for the register bank scoreboard: default register
//   width, default index width and the helper that turns an index width
//   into a register count.
package regbank_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 2;

  // Number of registers addressable by an index of addr_w bits.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regbank_scb_ctrl.sv
// regbank_scb_ctrl
//   Scoreboard control for the register bank: one busy bit per register,
//   the reserve grant decision and the registered busy-register counter.
//
// Ports
//   clk      in   clock, state updates on the rising edge
//   rst_n    in   asynchronous active-low reset
//   write    in   write enable
//   dr       in   write destination index
//   reserve  in   reserve request
//   rsvDr    in   register to reserve
//   rsvOk    out  combinational grant for the current reserve request
//   busy     out  current busy vector, one bit per register
//   busyCnt  out  number of busy registers
module regbank_scb_ctrl
  import regbank_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b0,
  localparam int DEPTH   = depth_of(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic [ADDR_W-1:0] dr,
  input  logic              reserve,
  input  logic [ADDR_W-1:0] rsvDr,
  output logic              rsvOk,
  output logic [DEPTH-1:0]  busy,
  output logic [ADDR_W:0]   busyCnt
);

  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;
  logic [ADDR_W:0]  cnt_reg;
  logic [ADDR_W:0]  cnt_next;
  logic             grant;
  logic             rsv_is_zero;
  logic             inc;
  logic             dec;

  // A busy register can still be granted when the write that frees it lands
  // in the same cycle; the reservation then takes over the freed slot.
  assign grant       = reserve && (!busy_reg[rsvDr] || (write && (dr == rsvDr)));
  assign rsv_is_zero = ZERO_REG && (rsvDr == '0);
  assign rsvOk       = grant;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_busy
      if (ZERO_REG && (gi == 0)) begin : g_pinned
        // Hard-wired zero register never becomes busy.
        assign busy_next[gi] = 1'b0;
      end else begin : g_live
        logic set_bit;
        logic clr_bit;
        assign set_bit = grant && (rsvDr == ADDR_W'(gi));
        assign clr_bit = write && (dr == ADDR_W'(gi));
        // Set has priority over clear: reserve wins a same-register collision.
        assign busy_next[gi] = set_bit ? 1'b1 : (clr_bit ? 1'b0 : busy_reg[gi]);
      end
    end
  endgenerate

  // Count only real transitions of a busy bit, so a same-register
  // reserve+write on a busy register leaves the count alone.
  assign inc = grant && !busy_reg[rsvDr] && !rsv_is_zero;
  assign dec = write && busy_reg[dr] && !(grant && (dr == rsvDr));

  always_comb begin
    cnt_next = cnt_reg;
    if (inc && !dec) begin
      cnt_next = cnt_reg + 1'b1;
    end else if (dec && !inc) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      busy_reg <= busy_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign busy    = busy_reg;
  assign busyCnt = cnt_reg;

endmodule

// File: rtl/regbank_scoreboard.sv
// regbank_scoreboard
//   Register bank with a per-register busy scoreboard. Two combinational read
//   ports, one write port, one reserve port. Optional write-to-read bypass and
//   optional hard-wired zero register 0.
//
// Ports
//   clk                in   clock, state updates on the rising edge
//   rst_n              in   asynchronous active-low reset
//   sr1, sr2           in   read indices
//   rdData1, rdData2   out  combinational read data
//   rdValid1, rdValid2 out  operand not pending
//   write, dr, wrData  in   write enable, destination index, write data
//   reserve, rsvDr     in   reserve request and target index
//   rsvOk              out  combinational reserve grant
//   busyCnt            out  number of busy registers
module regbank_scoreboard
  import regbank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1,
  localparam int DEPTH   = depth_of(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [ADDR_W-1:0] sr2,
  output logic [DATA_W-1:0] rdData1,
  output logic [DATA_W-1:0] rdData2,
  output logic              rdValid1,
  output logic              rdValid2,
  input  logic              write,
  input  logic [ADDR_W-1:0] dr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              reserve,
  input  logic [ADDR_W-1:0] rsvDr,
  output logic              rsvOk,
  output logic [ADDR_W:0]   busyCnt
);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  regbank_scb_ctrl #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .write   (write),
    .dr      (dr),
    .reserve (reserve),
    .rsvDr   (rsvDr),
    .rsvOk   (rsvOk),
    .busy    (busy),
    .busyCnt (busyCnt)
  );

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      logic wr_en;
      // The zero register is never written, so it holds its reset value.
      assign wr_en = write && (dr == ADDR_W'(gi)) && !(ZERO_REG && (gi == 0));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs[gi] <= '0;
        end else if (wr_en) begin
          regs[gi] <= wrData;
        end
      end
    end
  endgenerate

  logic hit1;
  logic hit2;
  logic zero1;
  logic zero2;

  assign zero1 = ZERO_REG && (sr1 == '0);
  assign zero2 = ZERO_REG && (sr2 == '0);
  assign hit1  = BYPASS && write && (dr == sr1);
  assign hit2  = BYPASS && write && (dr == sr2);

  // Zero register takes precedence over the bypass so a write to 0 never
  // leaks onto a read of 0.
  assign rdData1  = zero1 ? '0 : (hit1 ? wrData : regs[sr1]);
  assign rdData2  = zero2 ? '0 : (hit2 ? wrData : regs[sr2]);
  assign rdValid1 = zero1 || hit1 || !busy[sr1];
  assign rdValid2 = zero2 || hit2 || !busy[sr2];

endmodule

// File: tb/tb_regbank_scoreboard.sv
module tb_regbank_scoreboard;

  typedef struct packed {
    logic        wr;
    logic [1:0]  dr;
    logic [31:0] wd;
    logic        rsv;
    logic [1:0]  rd;
    logic [1:0]  s1;
    logic [1:0]  s2;
  } stim_t;

  typedef struct packed {
    logic [31:0] d1;
    logic        v1;
    logic [31:0] d2;
    logic        v2;
    logic        ok;
    logic [2:0]  cnt;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  // default instance: BYPASS=1, ZERO_REG=0
  logic [1:0]  sr1, sr2, dr, rsvDr;
  logic [31:0] wrData, rdData1, rdData2;
  logic        write, reserve, rdValid1, rdValid2, rsvOk;
  logic [2:0]  busyCnt;

  // alternate instance: BYPASS=0, ZERO_REG=1
  logic [1:0]  a_sr1, a_sr2, a_dr, a_rsvDr;
  logic [31:0] a_wrData, a_rdData1, a_rdData2;
  logic        a_write, a_reserve, a_rdValid1, a_rdValid2, a_rsvOk;
  logic [2:0]  a_busyCnt;

  int checks = 0;
  int errors = 0;
  obs_t exp_q[$];
  obs_t alt_q[$];
  logic [31:0] data_q[$];

  always #5 clk = ~clk;

  regbank_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .sr1(sr1), .sr2(sr2),
    .rdData1(rdData1), .rdData2(rdData2), .rdValid1(rdValid1), .rdValid2(rdValid2),
    .write(write), .dr(dr), .wrData(wrData), .reserve(reserve), .rsvDr(rsvDr),
    .rsvOk(rsvOk), .busyCnt(busyCnt)
  );

  regbank_scoreboard #(.BYPASS(1'b0), .ZERO_REG(1'b1)) dut_alt (
    .clk(clk), .rst_n(rst_n), .sr1(a_sr1), .sr2(a_sr2),
    .rdData1(a_rdData1), .rdData2(a_rdData2), .rdValid1(a_rdValid1), .rdValid2(a_rdValid2),
    .write(a_write), .dr(a_dr), .wrData(a_wrData), .reserve(a_reserve), .rsvDr(a_rsvDr),
    .rsvOk(a_rsvOk), .busyCnt(a_busyCnt)
  );

  function automatic stim_t st(input int wr, input int d, input logic [31:0] wd,
                               input int rsv, input int rd, input int s1, input int s2);
    stim_t s;
    s.wr  = 1'(wr);
    s.dr  = 2'(d);
    s.wd  = wd;
    s.rsv = 1'(rsv);
    s.rd  = 2'(rd);
    s.s1  = 2'(s1);
    s.s2  = 2'(s2);
    return s;
  endfunction

  function automatic obs_t ex(input logic [31:0] d1, input int v1, input logic [31:0] d2,
                              input int v2, input int ok, input int cnt);
    obs_t o;
    o.d1  = d1;
    o.v1  = 1'(v1);
    o.d2  = d2;
    o.v2  = 1'(v2);
    o.ok  = 1'(ok);
    o.cnt = 3'(cnt);
    return o;
  endfunction

  function automatic obs_t obs_main();
    obs_t o;
    o.d1 = rdData1; o.v1 = rdValid1; o.d2 = rdData2; o.v2 = rdValid2;
    o.ok = rsvOk;   o.cnt = busyCnt;
    return o;
  endfunction

  function automatic obs_t obs_alt();
    obs_t o;
    o.d1 = a_rdData1; o.v1 = a_rdValid1; o.d2 = a_rdData2; o.v2 = a_rdValid2;
    o.ok = a_rsvOk;   o.cnt = a_busyCnt;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("d1=%h v1=%b d2=%h v2=%b ok=%b cnt=%0d", o.d1, o.v1, o.d2, o.v2, o.ok, o.cnt);
  endfunction

  task automatic apply_main(input stim_t s);
    write = s.wr; dr = s.dr; wrData = s.wd; reserve = s.rsv; rsvDr = s.rd; sr1 = s.s1; sr2 = s.s2;
  endtask

  task automatic apply_alt(input stim_t s);
    a_write = s.wr; a_dr = s.dr; a_wrData = s.wd; a_reserve = s.rsv; a_rsvDr = s.rd;
    a_sr1 = s.s1; a_sr2 = s.s2;
  endtask

  task automatic test_reset();
    obs_t got, want;
    apply_main(st(0, 0, 32'h0, 0, 0, 2, 3));
    apply_alt(st(0, 0, 32'h0, 0, 0, 2, 3));
    rst_n = 1'b0;
    exp_q.push_back(ex(32'h0, 1, 32'h0, 1, 0, 0));
    #3;
    got = obs_main(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL reset_hold: got %s, expected %s", fmt(got), fmt(want));
    end else $display("txn reset_hold: %s", fmt(got));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(ex(32'h0, 1, 32'h0, 1, 0, 0));
    #1;
    got = obs_main(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL reset_release: got %s, expected %s", fmt(got), fmt(want));
    end else $display("txn reset_release: %s", fmt(got));
  endtask

  task automatic test_bypass();
    stim_t s[2]; obs_t e[2]; obs_t ea[2]; obs_t got, want;
    s[0] = st(1, 1, 32'hDEADBEEF, 0, 0, 1, 2);
    e[0] = ex(32'hDEADBEEF, 1, 32'h0, 1, 0, 0);
    ea[0] = ex(32'h0, 1, 32'h0, 1, 0, 0);
    s[1] = st(0, 0, 32'h0, 0, 0, 1, 2);
    e[1] = ex(32'hDEADBEEF, 1, 32'h0, 1, 0, 0);
    ea[1] = ex(32'hDEADBEEF, 1, 32'h0, 1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      apply_main(s[k]); apply_alt(s[k]);
      exp_q.push_back(e[k]); alt_q.push_back(ea[k]);
      #1;
      got = obs_main(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL bypass[%0d]: got %s, expected %s", k, fmt(got), fmt(want));
      end else $display("txn bypass[%0d]: %s", k, fmt(got));
      got = obs_alt(); want = alt_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL no_bypass[%0d]: got %s, expected %s", k, fmt(got), fmt(want));
      end else $display("txn no_bypass[%0d]: %s", k, fmt(got));
    end
  endtask

  task automatic test_reserve();
    stim_t s[4]; obs_t e[4]; obs_t got, want;
    s[0] = st(0, 0, 32'h0, 1, 2, 2, 1); e[0] = ex(32'h0, 1, 32'hDEADBEEF, 1, 1, 0);
    s[1] = st(0, 0, 32'h0, 1, 2, 2, 1); e[1] = ex(32'h0, 0, 32'hDEADBEEF, 1, 0, 1);
    s[2] = st(1, 2, 32'h5, 0, 0, 2, 1); e[2] = ex(32'h5, 1, 32'hDEADBEEF, 1, 0, 1);
    s[3] = st(0, 0, 32'h0, 0, 0, 2, 1); e[3] = ex(32'h5, 1, 32'hDEADBEEF, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      apply_main(s[k]);
      exp_q.push_back(e[k]);
      #1;
      got = obs_main(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL reserve[%0d]: got %s, expected %s", k, fmt(got), fmt(want));
      end else $display("txn reserve[%0d]: %s", k, fmt(got));
    end
  endtask

  task automatic test_same_cycle();
    stim_t s[5]; obs_t e[5]; obs_t got, want;
    s[0] = st(0, 0, 32'h0, 1, 3, 3, 2); e[0] = ex(32'h0, 1, 32'h5, 1, 1, 0);
    s[1] = st(1, 3, 32'hA, 1, 3, 3, 2); e[1] = ex(32'hA, 1, 32'h5, 1, 1, 1);
    s[2] = st(0, 0, 32'h0, 0, 0, 3, 2); e[2] = ex(32'hA, 0, 32'h5, 1, 0, 1);
    s[3] = st(0, 0, 32'h0, 1, 3, 3, 2); e[3] = ex(32'hA, 0, 32'h5, 1, 0, 1);
    s[4] = st(0, 0, 32'h0, 0, 0, 3, 2); e[4] = ex(32'hA, 0, 32'h5, 1, 0, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      apply_main(s[k]);
      exp_q.push_back(e[k]);
      #1;
      got = obs_main(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL same_cycle[%0d]: got %s, expected %s", k, fmt(got), fmt(want));
      end else $display("txn same_cycle[%0d]: %s", k, fmt(got));
    end
  endtask

  task automatic test_full_reset();
    stim_t s[4]; obs_t e[4]; obs_t got, want;
    s[0] = st(0, 0, 32'h0, 1, 0, 0, 1); e[0] = ex(32'h0, 1, 32'hDEADBEEF, 1, 1, 1);
    s[1] = st(0, 0, 32'h0, 1, 1, 0, 1); e[1] = ex(32'h0, 0, 32'hDEADBEEF, 1, 1, 2);
    s[2] = st(0, 0, 32'h0, 1, 2, 0, 1); e[2] = ex(32'h0, 0, 32'hDEADBEEF, 0, 1, 3);
    s[3] = st(0, 0, 32'h0, 0, 0, 2, 3); e[3] = ex(32'h5, 0, 32'hA, 0, 0, 4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      apply_main(s[k]);
      exp_q.push_back(e[k]);
      #1;
      got = obs_main(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL full[%0d]: got %s, expected %s", k, fmt(got), fmt(want));
      end else $display("txn full[%0d]: %s", k, fmt(got));
    end
    // Reset asserted between edges must act without a clock edge.
    @(negedge clk);
    apply_main(st(0, 0, 32'h0, 0, 0, 2, 3));
    #2;
    rst_n = 1'b0;
    exp_q.push_back(ex(32'h0, 1, 32'h0, 1, 0, 0));
    #1;
    got = obs_main(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL async_reset: got %s, expected %s", fmt(got), fmt(want));
    end else $display("txn async_reset: %s", fmt(got));
    // Write and reserve held across an edge during reset must be ignored.
    apply_main(st(1, 1, 32'h1234, 1, 1, 1, 2));
    @(posedge clk);
    @(negedge clk);
    apply_main(st(0, 0, 32'h0, 0, 0, 1, 2));
    rst_n = 1'b1;
    exp_q.push_back(ex(32'h0, 1, 32'h0, 1, 0, 0));
    #1;
    got = obs_main(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL post_reset: got %s, expected %s", fmt(got), fmt(want));
    end else $display("txn post_reset: %s", fmt(got));
  endtask

  task automatic test_back_to_back();
    logic [31:0] w, want;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      w = $urandom;
      apply_main(st(1, i, w, 0, 0, i, 3 - i));
      data_q.push_back(w);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      apply_main(st(0, 0, 32'h0, 0, 0, i, 3 - i));
      #1;
      want = data_q.pop_front(); checks++;
      if (rdData1 !== want || rdValid1 !== 1'b1) begin
        errors++;
        $display("FAIL b2b_read[%0d]: got d1=%h v1=%b, expected d1=%h v1=1", i, rdData1, rdValid1, want);
      end else $display("txn b2b_read[%0d]: d1=%h v1=%b", i, rdData1, rdValid1);
    end
  endtask

  task automatic test_zero_reg();
    stim_t s[5]; obs_t e[5]; obs_t got, want;
    s[0] = st(1, 0, 32'hFFFF, 0, 0, 0, 1); e[0] = ex(32'h0, 1, 32'h0, 1, 0, 0);
    s[1] = st(0, 0, 32'h0, 1, 0, 0, 1);    e[1] = ex(32'h0, 1, 32'h0, 1, 1, 0);
    s[2] = st(0, 0, 32'h0, 1, 1, 0, 1);    e[2] = ex(32'h0, 1, 32'h0, 1, 1, 0);
    s[3] = st(1, 1, 32'h77, 0, 0, 0, 1);   e[3] = ex(32'h0, 1, 32'h0, 0, 0, 1);
    s[4] = st(0, 0, 32'h0, 0, 0, 0, 1);    e[4] = ex(32'h0, 1, 32'h77, 1, 0, 0);
    apply_main(st(0, 0, 32'h0, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      apply_alt(s[k]);
      alt_q.push_back(e[k]);
      #1;
      got = obs_alt(); want = alt_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL zero_reg[%0d]: got %s, expected %s", k, fmt(got), fmt(want));
      end else $display("txn zero_reg[%0d]: %s", k, fmt(got));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, limit 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_bypass();
    test_reserve();
    test_same_cycle();
    test_full_reset();
    test_back_to_back();
    test_zero_reg();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
